issue_queue_ctrl: RTL
=====================

// Module: issue_queue_ctrl
// PURPOSE
//  In-order instruction queue and dispatch scheduler between IF and the Issue stage.
//  Buffers fetched instructions and releases one per cycle only when the ROB and the target
//  station have room: RS for non-memory ops, LSB for loads/stores. Back-pressures IF, drops
//  all contents on a ROB flush.
// PARAMETERS
//  QUEUE_LOG  2  log2 of queue depth; DEPTH = 2**QUEUE_LOG entries
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  rdy          in   1   global enable; when 0 every register holds its value
//  flush        in   1   ROB misprediction clear; drops queued and in-flight instructions
//  if_valid     in   1   IF presents an instruction this cycle
//  if_inst      in   32  instruction word
//  if_pc        in   32  PC of if_inst
//  iq_full      out  1   back-pressure to IF: count >= DEPTH-1 (combinational from count)
//  rob_full     in   1   ROB cannot take an entry beyond one currently flagged by issue_valid
//  rs_full      in   1   RS, same margin rule as rob_full
//  lsb_full     in   1   LSB, same margin rule as rob_full
//  issue_valid  out  1   registered: issue_inst/issue_pc valid for Issue this cycle
//  issue_inst   out  32  registered instruction to decode
//  issue_pc     out  32  registered PC
//  issue_is_mem out  1   registered: 1 = load/store (goes to LSB), 0 = RS
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, issue_valid=0, issue_inst=0, issue_pc=0, issue_is_mem=0.
//  - rst has priority over rdy; with rdy=0 and rst=0 no register changes.
//  - Storage: DEPTH x {inst, pc}; head/tail are QUEUE_LOG bits, wrap modulo DEPTH;
//    count is QUEUE_LOG+1 bits, range 0..DEPTH.
//  - is_mem(head) = head.inst[6:0] == 7'b0000011 (load) or 7'b0100011 (store).
//  - push = if_valid && count < DEPTH: write {if_inst,if_pc} at tail, tail+1.
//    if_valid with count==DEPTH is a protocol error (bench asserts it never occurs);
//    the instruction is discarded and no state changes.
//  - pop = count != 0 && !rob_full && (is_mem(head) ? !lsb_full : !rs_full).
//    On pop: issue_valid<=1, issue_inst/issue_pc<=head entry, issue_is_mem<=is_mem(head),
//    head+1. No pop: issue_valid<=0, other issue_* hold.
//  - Strictly in order: a blocked head blocks all younger entries (no bypass/reorder).
//  - Same-cycle push+pop: count unchanged; push uses pre-update count.
//  - No bypass when empty: if_valid sampled at edge t -> earliest issue_valid after edge t+1.
//    Sustained throughput 1 instr/cycle when nothing is full.
//  - flush (when rdy=1, rst=0): head=tail=0, count=0, issue_valid<=0; a same-cycle push and
//    pop are both suppressed. Storage contents are don't-care.
//  - rob/rs/lsb_full margin: downstream asserts full while it has <=1 free slot, so the
//    instruction issued in the same cycle always fits.
// TESTING
//  1 rst=1 one cycle -> issue_valid=0, iq_full=0, count=0; outputs zero.
//  2 Push ADDI(0x00100093,pc=0x0) then LW(0x0000A103,pc=0x4), nothing full -> issue_valid
//    two edges after each push; ADDI is_mem=0, then LW is_mem=1, back-to-back.
//  3 Queue LW then ADD with lsb_full=1, rs_full=0 -> no issue for 5 cycles; drop lsb_full ->
//    LW issues, ADD next cycle (no reorder).
//  4 rob_full=1, push 3 instrs (DEPTH=4) -> iq_full=1 once count=3; push 4th -> count=4;
//    release rob_full -> 4 issues in order on consecutive cycles, pcs 0x0,0x4,0x8,0xC.
//  5 Queue 3 entries, assert flush with simultaneous if_valid -> count=0, issue_valid=0 next
//    cycle; pushed instruction not issued; new push after flush issues normally.
//  6 rdy=0 for 4 cycles mid-stream with if_valid=1 -> count/head/tail/issue_* unchanged;
//    flow resumes from same entry when rdy=1.

Source files
------------

// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl: in-order instruction buffer between fetch and issue.
// The head entry is released only when the ROB and its target station (RS or LSB) have room.
module issue_queue_ctrl #(
  parameter int QUEUE_LOG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        iq_full,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  output logic        issue_valid,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_pc,
  output logic        issue_is_mem
);

  localparam int DEPTH    = 1 << QUEUE_LOG;
  localparam int DEPTH_M1 = DEPTH - 1;
  localparam logic [QUEUE_LOG:0] C_DEPTH     = DEPTH[QUEUE_LOG:0];
  localparam logic [QUEUE_LOG:0] C_FULL_MARK = DEPTH_M1[QUEUE_LOG:0];
  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;

  logic [31:0]          r_inst_q [DEPTH];
  logic [31:0]          r_pc_q   [DEPTH];
  logic [QUEUE_LOG-1:0] r_head;
  logic [QUEUE_LOG-1:0] r_tail;
  logic [QUEUE_LOG:0]   r_count;
  logic                 r_issue_valid;
  logic [31:0]          r_issue_inst;
  logic [31:0]          r_issue_pc;
  logic                 r_issue_is_mem;

  logic [31:0] w_head_inst;
  logic [31:0] w_head_pc;
  logic        w_head_is_mem;
  logic        w_push;
  logic        w_pop;
  logic        w_advance;

  always_comb begin
    w_head_inst   = r_inst_q[r_head];
    w_head_pc     = r_pc_q[r_head];
    w_head_is_mem = (w_head_inst[6:0] == C_OP_LOAD) || (w_head_inst[6:0] == C_OP_STORE);
  end

  // Downstream full flags already reserve one slot, so no extra margin is needed here.
  assign w_push    = if_valid && (r_count < C_DEPTH);
  assign w_pop     = (r_count != '0) && !rob_full && (w_head_is_mem ? !lsb_full : !rs_full);
  assign w_advance = !rst && rdy && !flush;

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (w_advance && w_push) begin
      r_inst_q[r_tail] <= if_inst;
      r_pc_q[r_tail]   <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_issue_valid  <= 1'b0;
      r_issue_inst   <= '0;
      r_issue_pc     <= '0;
      r_issue_is_mem <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_issue_valid <= 1'b0;
      end else begin
        r_issue_valid <= w_pop;
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head         <= r_head + 1'b1;
          r_issue_inst   <= w_head_inst;
          r_issue_pc     <= w_head_pc;
          r_issue_is_mem <= w_head_is_mem;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign iq_full      = (r_count >= C_FULL_MARK);
  assign issue_valid  = r_issue_valid;
  assign issue_inst   = r_issue_inst;
  assign issue_pc     = r_issue_pc;
  assign issue_is_mem = r_issue_is_mem;

endmodule
